fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR engine: one 16x16 multiplier and one accumulator sequenced over TAPS taps per sample.
//  Replaces the fully parallel multiplier array in the lab3 audio filter path.
//  Owns the circular sample buffer, a writable coefficient bank, and a valid/ready stream interface on each side.
//  Sits between the audio codec sample source and the codec DAC sink.
// PARAMETERS
//  TAPS   67  number of taps (coefficient indices 0..TAPS-1)
//  AW     7   address width of sample buffer and coefficient bank (2**AW >= TAPS)
//  ACC_W  40  accumulator width; must hold TAPS * 2**30 without overflow
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-high reset
//  in_valid    in   1   in_sample is valid
//  in_ready    out  1   engine accepts a sample this cycle
//  in_sample   in   16  signed Q1.15 input sample
//  out_valid   out  1   out_sample is valid; held until out_ready
//  out_ready   in   1   sink accepts out_sample
//  out_sample  out  16  signed Q1.15 filtered sample
//  coef_we     in   1   coefficient write strobe
//  coef_addr   in   AW  coefficient index (values >= TAPS are ignored)
//  coef_wdata  in   16  signed Q1.15 coefficient
//  coef_err    out  1   one-cycle pulse: coefficient write rejected
//  busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset values: state=CLEAR, wr_ptr=0, acc=0, in_ready=0, out_valid=0, out_sample=0, coef_err=0, busy=1.
//  - The coefficient bank is not cleared by reset; software reloads it after reset.
//  - Reset asserted mid-operation aborts immediately: any pending output is discarded and the engine re-enters CLEAR.
//  - FSM CLEAR: writes 0 to buffer[0..TAPS-1], one entry per cycle (TAPS cycles), then goes to IDLE.
//  - FSM IDLE: in_ready=1.
//    - On in_valid & in_ready: buffer[wr_ptr] <= in_sample; newest <= wr_ptr.
//    - wr_ptr advances; TAPS-1 wraps to 0.
//    - acc <= 0; k <= 0; next state MAC.
//  - FSM MAC: one tap per cycle: acc <= acc + buffer[(newest-k) mod TAPS] * coef[k] (signed 32-bit product).
//    - After k = TAPS-1, go to OUT.
//    - The MAC phase is exactly TAPS cycles.
//  - FSM OUT: out_sample = acc >>> 15, narrowed to 16 bits as described under CONFIGURATION; out_valid=1.
//    - out_sample and out_valid are held stable while out_ready=0.
//    - On out_ready, go to IDLE; out_valid drops the next cycle.
//  - Latency: out_valid rises TAPS+1 cycles after the accepting edge.
//    - Max throughput is one sample per TAPS+2 cycles (out_ready tied high).
//  - in_ready=0 in CLEAR, MAC and OUT; an input presented then is not consumed (it is the source's job to hold it).
//  - Coefficient writes:
//    - Accepted only in IDLE with coef_addr < TAPS; written at the clock edge.
//    - A write in the same cycle as a sample accept takes effect for that sample's MAC.
//    - Writes in CLEAR/MAC/OUT, or with coef_addr >= TAPS, are dropped and coef_err pulses 1 cycle.
//  - Arithmetic: products are 32-bit signed and sign-extended to ACC_W; the shift is arithmetic.
// CONFIGURATION
//  - Macro FIR_SAT_EN defined:
//    - out_sample = (acc >>> 15) clamped to [-32768, 32767].
//  - FIR_SAT_EN undefined:
//    - out_sample = (acc >>> 15)[15:0]; two's-complement wrap, no clamp logic.
// TESTING
//  1. reset pulse -> in_ready=0 for exactly 67 cycles after deassert, then 1; out_valid=0 throughout.
//  2. coef[0]=32767, others 0; send 1000 -> out_sample=999 after 68 cycles.
//     - Next sample 0 -> out_sample=0.
//  3. coef[k]=k+1 for k=0..66; impulse 16384 then 66 zeros -> outputs 0,1,1,2,2,3... (=(k+1)>>1).
//  4. Hold out_ready=0 for 5 cycles in OUT -> out_sample/out_valid stable; in_ready=0.
//     - Pulsing in_valid does not advance wr_ptr.
//  5. coef_we during MAC, and coef_addr=70 in IDLE -> coef_err pulses once each; the next output is unchanged.
//  6. All coef=32767; 67 samples of 32767 -> last out: 32767 with FIR_SAT_EN, 32634 without.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Time-multiplexed FIR: one 16x16 MAC sequenced over TAPS taps per
//            sample, with circular sample buffer and writable coefficient bank.
// Options  : FIR_SAT_EN - clamp the output to the Q1.15 range instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS  = 67,
    parameter int AW    = 7,
    parameter int ACC_W = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_sample,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_sample,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [15:0]   coef_wdata,
    output logic          coef_err,
    output logic          busy
);

    localparam logic [1:0]    S_CLEAR = 2'd0;
    localparam logic [1:0]    S_IDLE  = 2'd1;
    localparam logic [1:0]    S_MAC   = 2'd2;
    localparam logic [1:0]    S_OUT   = 2'd3;
    localparam logic [AW-1:0] C_LAST  = AW'(TAPS - 1);
    localparam logic [AW:0]   C_TAPS  = (AW + 1)'(TAPS);

    logic [1:0]              state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             out_sample_q, out_sample_d;
    logic                    coef_err_q, coef_err_d;

    logic [15:0] buf_mem  [TAPS];
    logic [15:0] coef_mem [TAPS];

    logic                    w_buf_we;
    logic [AW-1:0]           w_buf_addr;
    logic [15:0]             w_buf_wdata;
    logic                    w_coef_ok;
    logic                    w_coef_wr;
    logic signed [15:0]      w_tap;
    logic signed [15:0]      w_coef;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic [15:0]             w_narrow;

    assign w_coef_ok = ({1'b0, coef_addr} < C_TAPS);
    assign w_coef_wr = coef_we && (state_q == S_IDLE) && w_coef_ok;

    // rd_ptr walks backwards from the newest sample while k walks the bank
    assign w_tap     = buf_mem[rd_ptr_q];
    assign w_coef    = coef_mem[k_q];
    assign w_prod    = w_tap * w_coef;
    assign w_acc_sum = acc_q + {{(ACC_W - 32){w_prod[31]}}, w_prod};

`ifdef FIR_SAT_EN
    logic w_ovf;
    assign w_ovf    = !((&w_acc_sum[ACC_W-1:30]) || !(|w_acc_sum[ACC_W-1:30]));
    assign w_narrow = w_ovf ? (w_acc_sum[ACC_W-1] ? 16'h8000 : 16'h7FFF)
                            : w_acc_sum[30:15];
`else
    assign w_narrow = w_acc_sum[30:15];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            coef_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            out_sample_q <= out_sample_d;
            coef_err_q   <= coef_err_d;
        end
    end

    // Storage is deliberately unreset; CLEAR scrubs the sample buffer instead
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            buf_mem[w_buf_addr] <= w_buf_wdata;
        end
        if (w_coef_wr) begin
            coef_mem[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        k_d          = k_q;
        acc_d        = acc_q;
        out_sample_d = out_sample_q;
        coef_err_d   = coef_we && !w_coef_wr;
        w_buf_we     = 1'b0;
        w_buf_addr   = k_q;
        w_buf_wdata  = 16'h0000;

        case (state_q)
            S_CLEAR: begin
                w_buf_we   = 1'b1;
                w_buf_addr = k_q;
                if (k_q == C_LAST) begin
                    k_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    w_buf_we    = 1'b1;
                    w_buf_addr  = wr_ptr_q;
                    w_buf_wdata = in_sample;
                    rd_ptr_d    = wr_ptr_q;
                    wr_ptr_d    = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
                    acc_d       = '0;
                    k_d         = '0;
                    state_d     = S_MAC;
                end
            end
            S_MAC: begin
                acc_d    = w_acc_sum;
                rd_ptr_d = (rd_ptr_q == '0) ? C_LAST : rd_ptr_q - 1'b1;
                if (k_q == C_LAST) begin
                    out_sample_d = w_narrow;
                    state_d      = S_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
    end

    assign out_sample = out_sample_q;
    assign coef_err   = coef_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Scoreboard bench for fir_mac_sequencer; expected outputs are
//            queued at issue and popped by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int TAPS = 67;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sample;
    logic        coef_we = 1'b0;
    logic [6:0]  coef_addr = 7'd0;
    logic [15:0] coef_wdata = 16'h0000;
    logic        coef_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] exp_q [$];

    fir_mac_sequencer #(.TAPS(TAPS), .AW(7), .ACC_W(40)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_err  (coef_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, required event", name);
    endtask

    // Output monitor: one pop per accepted output beat
    always @(negedge clk) begin
        logic signed [15:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0d, required no output", $signed(out_sample));
            end else begin
                e = exp_q.pop_front();
                check("out_sample", $signed(out_sample), e);
            end
        end
    end

    task automatic do_reset();
        int cnt;
        bit ov;
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_busy", busy, 1);
        reset = 1'b0;
        cnt = 0;
        ov  = 1'b0;
        while (!in_ready && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid) ov = 1'b1;
        end
        check("clear_cycles", cnt, TAPS);
        check("clear_out_valid", ov, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic write_coef(input logic [6:0] a, input logic [15:0] d, input bit exp_err);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err", coef_err, exp_err);
        if (exp_err) begin
            @(negedge clk);
            check("coef_err_pulse_len", coef_err, 0);
        end
    endtask

    task automatic send(input logic [15:0] s, input logic signed [15:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            flag("send_in_ready");
        end else begin
            exp_q.push_back(e);
            in_valid  = 1'b1;
            in_sample = s;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            flag("drain");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic signed [15:0] model_full(input int m);
        longint acc;
        longint sh;
        acc = longint'(m) * 32767 * 32767;
        sh  = acc >>> 15;
`ifdef FIR_SAT_EN
        if (sh > 32767)  return 16'sh7FFF;
        if (sh < -32768) return 16'sh8000;
`endif
        return sh[15:0];
    endfunction

    initial begin
        int cnt;
        logic [15:0] held;

        // Reset, CLEAR length
        do_reset();

        // Single-tap filter: 1000 * 32767 >> 15 = 999, latency check
        write_coef(7'd0, 16'sd32767, 1'b0);
        for (int k = 1; k < TAPS; k++) write_coef(7'(k), 16'h0000, 1'b0);
        @(negedge clk);
        exp_q.push_back(16'sd999);
        in_valid  = 1'b1;
        in_sample = 16'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        // Cycles counted with the accepting cycle as cycle 0
        check("latency", cnt, TAPS + 1);
        drain();
        send(16'd0, 16'sd0);
        drain();

        // Ramp coefficients, impulse response (k+1)>>1
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(7'(k), 16'(k + 1), 1'b0);
        send(16'd16384, 16'sd0);
        drain();
        for (int n = 1; n < TAPS; n++) begin
            if (n == 2) begin
                out_ready = 1'b0;
                send(16'd0, 16'((n + 1) >> 1));
                cnt = 0;
                while (!out_valid && cnt < 300) begin
                    @(negedge clk);
                    cnt++;
                end
                if (!out_valid) flag("hold_wait");
                held = out_sample;
                for (int i = 0; i < 5; i++) begin
                    in_valid  = (i % 2 == 0);
                    in_sample = 16'd7777;
                    @(negedge clk);
                    check("hold_out_valid", out_valid, 1);
                    check("hold_out_sample", out_sample, held);
                    check("hold_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end else if (n == 4) begin
                send(16'd0, 16'((n + 1) >> 1));
                write_coef(7'd4, 16'hFC18, 1'b1);
            end else begin
                send(16'd0, 16'((n + 1) >> 1));
            end
            drain();
            if (n == 5) write_coef(7'd70, 16'h1234, 1'b1);
        end

        // Reset mid-MAC discards the pending result
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        do_reset();

        // Full-scale input on all taps: wrap vs clamp
        for (int k = 0; k < TAPS; k++) write_coef(7'(k), 16'h7FFF, 1'b0);
        for (int m = 1; m <= TAPS; m++) begin
            if (m == TAPS) begin
`ifdef FIR_SAT_EN
                send(16'h7FFF, 16'sd32767);
`else
                send(16'h7FFF, 16'sd32634);
`endif
            end else begin
                send(16'h7FFF, model_full(m));
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
